// File: rtl/ddr_wr_pkg.sv
// Shared definitions for the DDR write-burst master: FSM encoding,
// burst sizing helpers and the burst configuration legality check.
package ddr_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_t;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_BURST_LEN  = 64;
    localparam int unsigned BYTES_PER_BEAT = DEF_DATA_WIDTH / 8;
    localparam int unsigned BURST_BYTES    = DEF_BURST_LEN * BYTES_PER_BEAT;

    function automatic int unsigned bytes_per_beat(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned burst_bytes(input int unsigned burst_len,
                                                input int unsigned data_width);
        return burst_len * bytes_per_beat(data_width);
    endfunction

    // AXI allows 1..256 beats; a frame must split into whole bursts.
    function automatic bit burst_cfg_ok(input int unsigned burst_len,
                                        input int unsigned frame_beats);
        if (burst_len < 1 || burst_len > 256) return 1'b0;
        return (frame_beats % burst_len) == 0;
    endfunction

endpackage

// File: rtl/ddr_wr_burst_master_skid.sv
// Latency-1 FIFO read port to valid/ready adapter with a 2-entry skid buffer.
// Reads are only issued while the parent grants budget via rd_allow.
module fifo_rd_skid #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_allow,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [1:0]            cnt;
    logic                  in_flight;
    logic                  pop;
    logic [1:0]            pending;
    logic [DATA_WIDTH-1:0] ent0;
    logic [DATA_WIDTH-1:0] ent1;

    assign out_valid = (cnt != 2'd0);
    assign out_data  = out_valid ? ent0 : '0;
    assign pop       = out_valid && out_ready;

    // Counting the departing beat as a free slot keeps the loop at 1 beat/cycle.
    assign pending    = cnt + {1'b0, in_flight} - {1'b0, pop};
    assign fifo_rd_en = !rst && rd_allow && !fifo_rd_empty && (pending < 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 2'd0;
            in_flight <= 1'b0;
        end else begin
            in_flight <= fifo_rd_en;
            case ({in_flight, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_flight && pop) begin
            if (cnt == 2'd1) begin
                ent0 <= fifo_rd_data;
            end else begin
                ent0 <= ent1;
                ent1 <= fifo_rd_data;
            end
        end else if (in_flight) begin
            if (cnt == 2'd0) ent0 <= fifo_rd_data;
            else             ent1 <= fifo_rd_data;
        end else if (pop) begin
            ent0 <= ent1;
        end
    end

endmodule

// File: rtl/ddr_wr_burst_master.sv
// Drains buffered pixel-line FIFO data into fixed-length AXI write bursts,
// walking the frame buffer and rotating through BUF_NUM buffers per frame.
module ddr_wr_burst_master
    import ddr_wr_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 28,
    parameter int          DATA_WIDTH   = 32,
    parameter int          BURST_LEN    = 64,
    parameter int          FRAME_BEATS  = 460800,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] FRAME_STRIDE = 32'h0040_0000,
    parameter int          BUF_NUM      = 3,
    parameter int          WL_WIDTH     = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    output logic                    fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
    input  logic                    fifo_rd_empty,
    input  logic [WL_WIDTH-1:0]     fifo_rd_water_level,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [1:0]              buf_idx,
    output logic                    frame_done,
    output logic                    busy
);

    localparam int unsigned BURST_STEP = burst_bytes(BURST_LEN, DATA_WIDTH);
    localparam bit          CFG_OK     = burst_cfg_ok(BURST_LEN, FRAME_BEATS);
    localparam int          FB_W       = $clog2(FRAME_BEATS + 1);

    wr_state_t       state;
    logic [FB_W-1:0] beat_cnt;
    logic [8:0]      rd_cnt;
    logic [8:0]      wbeat;
    logic            frame_active;
    logic            start_pending;
    logic [1:0]      nxt_idx;
    logic            level_ok;
    logic            rd_allow;
    logic            beat_fire;

    function automatic logic [ADDR_WIDTH-1:0] buf_base(input logic [1:0] idx);
        logic [31:0] off;
        off = BASE_ADDR + ({30'd0, idx} * FRAME_STRIDE);
        return off[ADDR_WIDTH-1:0];
    endfunction

    assign awlen     = 8'(BURST_LEN - 1);
    assign wstrb     = '1;
    assign bready    = 1'b1;
    assign busy      = (state != ST_IDLE);
    assign nxt_idx   = (buf_idx == 2'(BUF_NUM - 1)) ? 2'd0 : buf_idx + 2'd1;
    assign level_ok  = (fifo_rd_water_level >= WL_WIDTH'(BURST_LEN));
    assign rd_allow  = (state == ST_DATA) && (rd_cnt < 9'(BURST_LEN));
    assign beat_fire = wvalid && wready;

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk           (clk),
        .rst           (rst),
        .rd_allow      (rd_allow),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .out_valid     (wvalid),
        .out_ready     (wready),
        .out_data      (wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            awvalid       <= 1'b0;
            wlast         <= 1'b0;
            frame_done    <= 1'b0;
            awaddr        <= BASE_ADDR[ADDR_WIDTH-1:0];
            buf_idx       <= 2'(BUF_NUM - 1);
            beat_cnt      <= '0;
            rd_cnt        <= '0;
            wbeat         <= '0;
            frame_active  <= 1'b0;
            start_pending <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (fifo_rd_en)  rd_cnt        <= rd_cnt + 9'd1;
            if (frame_start) start_pending <= 1'b1;
            case (state)
                ST_IDLE: begin
                    // A new frame is only adopted between bursts, never mid-burst.
                    if (frame_start || start_pending) begin
                        buf_idx       <= nxt_idx;
                        awaddr        <= buf_base(nxt_idx);
                        beat_cnt      <= '0;
                        frame_active  <= 1'b1;
                        start_pending <= 1'b0;
                    end else if (CFG_OK && frame_active && level_ok) begin
                        state   <= ST_ADDR;
                        awvalid <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        state   <= ST_DATA;
                        rd_cnt  <= '0;
                        wbeat   <= '0;
                        wlast   <= (BURST_LEN == 1);
                    end
                end
                ST_DATA: begin
                    if (beat_fire) begin
                        wbeat <= wbeat + 9'd1;
                        wlast <= (wbeat + 9'd1 == 9'(BURST_LEN - 1));
                        if (wlast) begin
                            state    <= ST_RESP;
                            wlast    <= 1'b0;
                            awaddr   <= awaddr + ADDR_WIDTH'(BURST_STEP);
                            beat_cnt <= beat_cnt + FB_W'(BURST_LEN);
                            if (beat_cnt + FB_W'(BURST_LEN) == FB_W'(FRAME_BEATS))
                                frame_active <= 1'b0;
                        end
                    end
                end
                ST_RESP: begin
                    if (bvalid) begin
                        state      <= ST_IDLE;
                        frame_done <= !frame_active;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_wr_burst_master.sv
// Directed bench for ddr_wr_burst_master with a 256-beat frame (4 bursts of 64).
module tb_ddr_wr_burst_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data = 32'd0;
    logic        fifo_rd_empty;
    logic [12:0] wl = 13'd0;
    logic [27:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [1:0]  buf_idx;
    logic        frame_done;
    logic        busy;

    logic        wready_fixed = 1'b0;
    logic        rand_mode = 1'b0;
    logic        wr_rand = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] fifo_mem [0:4095];
    int          rd_ptr = 0;

    int          cyc = 0;
    int          beats = 0;
    int          rd_pulses = 0;
    int          fd_cnt = 0;
    int          last_seen = 0;
    int          last_acked = 0;
    int          aw_cyc0 = 0;
    int          b1_first = 0;
    int          b1_last = 0;
    logic [27:0] aw_q [$];
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = 32'd0;
    logic        fd_prev = 1'b0;

    ddr_wr_burst_master #(
        .ADDR_WIDTH   (28),
        .DATA_WIDTH   (32),
        .BURST_LEN    (64),
        .FRAME_BEATS  (256),
        .BASE_ADDR    (32'h0000_0000),
        .FRAME_STRIDE (32'h0040_0000),
        .BUF_NUM      (3),
        .WL_WIDTH     (13)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .frame_start         (frame_start),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_rd_water_level (wl),
        .awaddr              (awaddr),
        .awlen               (awlen),
        .awvalid             (awvalid),
        .awready             (awready),
        .wdata               (wdata),
        .wstrb               (wstrb),
        .wlast               (wlast),
        .wvalid              (wvalid),
        .wready              (wready),
        .bvalid              (bvalid),
        .bready              (bready),
        .buf_idx             (buf_idx),
        .frame_done          (frame_done),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    assign wready        = rand_mode ? wr_rand : wready_fixed;
    assign fifo_rd_empty = (rd_ptr >= 4096);

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Latency-1 FIFO model holding 0,1,2,...
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= fifo_mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        wr_rand = 1'($urandom_range(0, 1));
        if (bvalid) bvalid = 1'b0;
        else if (last_seen > last_acked) begin
            last_acked++;
            bvalid = 1'b1;
        end
    end

    // Handshakes seen here complete on the following rising edge.
    always @(negedge clk) begin
        cyc++;
        if (fifo_rd_en) rd_pulses++;
        if (awvalid && awready) begin
            if (aw_q.size() == 0) aw_cyc0 = cyc;
            check_vec("awlen", 64'(awlen), 64'd63);
            aw_q.push_back(awaddr);
        end
        if (stall_prev) begin
            check_vec("w_hold_valid", 64'(wvalid), 64'd1);
            check_vec("w_hold_data", 64'(wdata), 64'(stall_data));
        end
        stall_prev = wvalid && !wready && !rst;
        stall_data = wdata;
        if (wvalid && wready) begin
            check_vec("wdata", 64'(wdata), 64'(beats));
            check_vec("wlast", 64'(wlast), 64'((beats % 64) == 63));
            if (beats == 0)  b1_first = cyc;
            if (beats == 63) b1_last  = cyc;
            if (wlast) last_seen++;
            beats++;
        end
        if (frame_done) begin
            check_vec("frame_done_single", 64'(fd_prev), 64'd0);
            fd_cnt++;
        end
        fd_prev = frame_done;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int cur_count(input int which);
        case (which)
            0:       return beats;
            1:       return aw_q.size();
            default: return fd_cnt;
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc && cur_count(which) < target; i++) tick(1);
        check_vec(tag, 64'(cur_count(which)), 64'(target));
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) fifo_mem[i] = 32'(i);

        tick(3);
        check_vec("rst_awvalid", 64'(awvalid), 64'd0);
        check_vec("rst_wvalid", 64'(wvalid), 64'd0);
        check_vec("rst_wlast", 64'(wlast), 64'd0);
        check_vec("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check_vec("rst_frame_done", 64'(frame_done), 64'd0);
        check_vec("rst_busy", 64'(busy), 64'd0);
        check_vec("rst_awaddr", 64'(awaddr), 64'h0);
        check_vec("rst_buf_idx", 64'(buf_idx), 64'd2);
        check_vec("rst_wdata", 64'(wdata), 64'd0);
        check_vec("awlen_const", 64'(awlen), 64'd63);
        check_vec("wstrb", 64'(wstrb), 64'hF);
        check_vec("bready", 64'(bready), 64'd1);

        rst = 1'b0;
        wl  = 13'd63;
        tick(2);
        pulse_start();
        tick(5);
        check_vec("wl63_no_aw", 64'(awvalid), 64'd0);
        check_vec("wl63_busy", 64'(busy), 64'd0);
        check_vec("f1_buf_idx", 64'(buf_idx), 64'd0);
        check_vec("f1_awaddr", 64'(awaddr), 64'h0);

        wl = 13'd64;
        tick(3);
        check_vec("wl64_awvalid", 64'(awvalid), 64'd1);
        check_vec("wl64_awaddr", 64'(awaddr), 64'h0);
        check_vec("wl64_busy", 64'(busy), 64'd1);
        tick(3);
        check_vec("aw_held", 64'(awvalid), 64'd1);
        check_vec("no_w_before_aw", 64'(wvalid), 64'd0);
        check_vec("no_rd_before_aw", 64'(fifo_rd_en), 64'd0);

        // Burst 1: full-rate sink.
        awready      = 1'b1;
        wready_fixed = 1'b1;
        wait_for(0, 64, 400, "b1_beats");
        check_vec("b1_rd_pulses", 64'(rd_pulses), 64'd64);
        check_vec("b1_awaddr", 64'(aw_q[0]), 64'h0);
        check_vec("b1_first_w_lat_ok", 64'((b1_first - aw_cyc0) <= 3), 64'd1);
        check_vec("b1_throughput", 64'(b1_last - b1_first), 64'd63);
        check_vec("b1_next_awaddr", 64'(awaddr), 64'h100);

        // Burst 2: random backpressure.
        rand_mode = 1'b1;
        wait_for(0, 128, 1500, "b2_beats");
        rand_mode = 1'b0;
        check_vec("b2_awaddr", 64'(aw_q[1]), 64'h100);

        // Burst 3: new frame announced mid-burst.
        wait_for(0, 138, 400, "b3_mid");
        pulse_start();
        wait_for(1, 4, 600, "f2_aw_seen");
        check_vec("b3_awaddr", 64'(aw_q[2]), 64'h200);
        check_vec("b3_full_beats", 64'(beats), 64'd192);
        check_vec("f2_awaddr", 64'(aw_q[3]), 64'h040_0000);
        check_vec("f2_buf_idx", 64'(buf_idx), 64'd1);

        wait_for(2, 1, 2000, "f2_frame_done");
        check_vec("f2_beats", 64'(beats), 64'd448);
        check_vec("f2_aw_count", 64'(aw_q.size()), 64'd7);
        for (int i = 1; i < 4; i++)
            check_vec("f2_burst_addr", 64'(aw_q[3 + i]), 64'h040_0000 + 64'(i * 256));
        tick(30);
        check_vec("no_5th_aw", 64'(aw_q.size()), 64'd7);
        check_vec("idle_after_frame", 64'(busy), 64'd0);
        check_vec("fd_low_after", 64'(frame_done), 64'd0);

        pulse_start();
        wait_for(2, 2, 2000, "f3_frame_done");
        check_vec("f3_awaddr", 64'(aw_q[7]), 64'h080_0000);
        check_vec("f3_buf_idx", 64'(buf_idx), 64'd2);
        check_vec("f3_aw_count", 64'(aw_q.size()), 64'd11);

        pulse_start();
        wait_for(1, 12, 200, "f4_aw_seen");
        check_vec("f4_wrap_awaddr", 64'(aw_q[11]), 64'h0);
        check_vec("f4_wrap_buf_idx", 64'(buf_idx), 64'd0);

        // Reset in the tenth cycle of DATA.
        tick(9);
        rst = 1'b1;
        tick(1);
        check_vec("mid_rst_wvalid", 64'(wvalid), 64'd0);
        check_vec("mid_rst_awvalid", 64'(awvalid), 64'd0);
        check_vec("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check_vec("mid_rst_busy", 64'(busy), 64'd0);
        check_vec("mid_rst_buf_idx", 64'(buf_idx), 64'd2);
        check_vec("mid_rst_awaddr", 64'(awaddr), 64'h0);
        check_vec("mid_rst_wlast", 64'(wlast), 64'd0);
        rst = 1'b0;
        tick(3);
        check_vec("post_rst_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
